// File: rtl/re_pkg.sv
// rtl/re_pkg.sv - shared capture-state encoding and RE_Control strobe map
package re_pkg;

  localparam int CAP_STATE_W = 3;

  typedef enum logic [CAP_STATE_W-1:0] {
    IDLE    = 3'b000,
    ARMED   = 3'b001,
    WAIT_R1 = 3'b010,
    WAIT_R2 = 3'b011,
    SEND    = 3'b100
  } cap_state_e;

  // Edge-tracked RE_Control strobes, packed into one vector for re_edge_detect
  localparam int STB_W      = 3;
  localparam int STB_ERASE  = 0;
  localparam int STB_EXPOSE = 1;
  localparam int STB_ADC    = 2;

  // Exactly one row select must be active for a conversion to be meaningful
  function automatic logic row_sel_ok(input logic nre_1, input logic nre_2);
    return nre_1 ^ nre_2;
  endfunction

endpackage

// File: rtl/re_readout_capture_if.sv
// rtl/re_readout_capture_if.sv - RE_Control strobes plus pixel stream bundle
interface re_readout_capture_if #(
  parameter int DATA_W = 8,
  parameter int NCOL   = 2,
  parameter int FCNT_W = 8
);
  import re_pkg::*;

  localparam int IDX_W = $clog2(2*NCOL);

  logic                   erase;
  logic                   expose;
  logic                   nre_1;
  logic                   nre_2;
  logic                   adc;
  logic [NCOL*DATA_W-1:0] col_data;
  logic                   pix_ready;
  logic                   err_clear;
  logic [DATA_W-1:0]      pix_data;
  logic                   pix_valid;
  logic [IDX_W-1:0]       pix_index;
  logic                   frame_last;
  logic [FCNT_W-1:0]      frame_count;
  logic                   err_protocol;
  logic                   err_overrun;
  logic [CAP_STATE_W-1:0] cap_fsm;

  // Controller / frame-sink side
  modport master (
    output erase, expose, nre_1, nre_2, adc, col_data, pix_ready, err_clear,
    input  pix_data, pix_valid, pix_index, frame_last, frame_count,
           err_protocol, err_overrun, cap_fsm
  );

  // Capture-block side
  modport slave (
    input  erase, expose, nre_1, nre_2, adc, col_data, pix_ready, err_clear,
    output pix_data, pix_valid, pix_index, frame_last, frame_count,
           err_protocol, err_overrun, cap_fsm
  );

endinterface

// File: rtl/re_edge_detect.sv
// rtl/re_edge_detect.sv - registered copy of a strobe vector with rise/fall flags
module re_edge_detect #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] d_q;
  logic [W-1:0] d_d;

  // Next value of the history register is simply the current strobe level
  always_comb begin
    d_d = d;
  end

  // One-cycle history of each strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= '0;
    else        d_q <= d_d;
  end

  // Edges are visible in the same cycle the strobe changes
  always_comb begin
    rise = d & ~d_q;
    fall = ~d & d_q;
  end

endmodule

// File: rtl/re_readout_capture.sv
// rtl/re_readout_capture.sv - RE_Control receiver: 2-row frame capture and pixel streamer
module re_readout_capture
  import re_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NCOL   = 2,
  parameter int FCNT_W = 8
) (
  input  logic                      IN_Clock,
  input  logic                      IN_Reset,
  input  logic                      IN_Erase,
  input  logic                      IN_Expose,
  input  logic                      IN_NRE_1,
  input  logic                      IN_NRE_2,
  input  logic                      IN_ADC,
  input  logic [NCOL*DATA_W-1:0]    IN_Col_data,
  input  logic                      IN_Pix_ready,
  input  logic                      IN_Err_clear,
  output logic [DATA_W-1:0]         OUT_Pix_data,
  output logic                      OUT_Pix_valid,
  output logic [$clog2(2*NCOL)-1:0] OUT_Pix_index,
  output logic                      OUT_Frame_last,
  output logic [FCNT_W-1:0]         OUT_Frame_count,
  output logic                      OUT_Err_protocol,
  output logic                      OUT_Err_overrun,
  output logic [CAP_STATE_W-1:0]    OUT_Cap_FSM
);

  localparam int NWORD    = 2*NCOL;
  localparam int IDX_W    = $clog2(NWORD);
  localparam int ROW_W    = NCOL*DATA_W;
  localparam int LAST_IDX = NWORD-1;

  logic [STB_W-1:0] stb;
  logic [STB_W-1:0] stb_rise;
  logic [STB_W-1:0] stb_fall;
  logic             erase_rise;
  logic             expose_fall;
  logic             adc_rise;
  logic             strobe_conflict;
  logic             unused_stb;

  cap_state_e         state_q,   state_d;
  logic [2*ROW_W-1:0] frame_q,   frame_d;
  logic               valid_q,   valid_d;
  logic [IDX_W-1:0]   idx_q,     idx_d;
  logic [FCNT_W-1:0]  fcnt_q,    fcnt_d;
  logic               err_p_q,   err_p_d;
  logic               err_o_q,   err_o_d;
  logic [DATA_W-1:0]  pix_data;
  cap_state_e         st;

  // Pack the edge-tracked strobes
  always_comb begin
    stb             = '0;
    stb[STB_ERASE]  = IN_Erase;
    stb[STB_EXPOSE] = IN_Expose;
    stb[STB_ADC]    = IN_ADC;
  end

  re_edge_detect #(.W(STB_W)) u_edge (
    .clk   (IN_Clock),
    .rst_n (IN_Reset),
    .d     (stb),
    .rise  (stb_rise),
    .fall  (stb_fall)
  );

  assign erase_rise      = stb_rise[STB_ERASE];
  assign expose_fall     = stb_fall[STB_EXPOSE];
  assign adc_rise        = stb_rise[STB_ADC];
  assign strobe_conflict = IN_Expose & IN_Erase;
  assign unused_stb      = ^{stb_rise[STB_EXPOSE], stb_fall[STB_ERASE], stb_fall[STB_ADC]};

  // Capture sequencing, stream handshake and error flags; Erase is resolved
  // before ADC so a simultaneous pair judges ADC against the post-erase state
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    fcnt_d  = fcnt_q;
    err_p_d = err_p_q;
    err_o_d = err_o_q;
    st      = state_q;

    if (IN_Err_clear) begin
      err_p_d = 1'b0;
      err_o_d = 1'b0;
    end

    if (strobe_conflict) err_p_d = 1'b1;

    if (state_q == SEND) begin
      if (erase_rise || adc_rise) err_o_d = 1'b1;
      if (valid_q && IN_Pix_ready) begin
        if (idx_q == IDX_W'(LAST_IDX)) begin
          valid_d = 1'b0;
          idx_d   = '0;
          fcnt_d  = fcnt_q + FCNT_W'(1);
          st      = IDLE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
      end
    end else begin
      // Erase arms from IDLE and aborts a partial capture; stale row data is
      // always overwritten by the next row-1 conversion before it can stream
      if (erase_rise && !strobe_conflict) st = ARMED;
      if (expose_fall && (st == ARMED)) st = WAIT_R1;
      if (adc_rise) begin
        if ((st == IDLE) || (st == ARMED) || !row_sel_ok(IN_NRE_1, IN_NRE_2)) begin
          err_p_d = 1'b1;
        end else if (st == WAIT_R1) begin
          if (IN_NRE_1) begin
            frame_d[0 +: ROW_W] = IN_Col_data;
            st                  = WAIT_R2;
          end else begin
            err_p_d = 1'b1;
          end
        end else begin
          if (IN_NRE_2) begin
            frame_d[ROW_W +: ROW_W] = IN_Col_data;
            st                      = SEND;
            valid_d                 = 1'b1;
            idx_d                   = '0;
          end else begin
            err_p_d = 1'b1;
          end
        end
      end
    end

    state_d = st;
  end

  // All capture/stream state updates together
  always_ff @(posedge IN_Clock or negedge IN_Reset) begin
    if (!IN_Reset) begin
      state_q <= IDLE;
      frame_q <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      fcnt_q  <= '0;
      err_p_q <= 1'b0;
      err_o_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      fcnt_q  <= fcnt_d;
      err_p_q <= err_p_d;
      err_o_q <= err_o_d;
    end
  end

  // Word select from the frame buffer, row-major with row 1 first
  always_comb begin
    pix_data = '0;
    for (int i = 0; i < NWORD; i++) begin
      if (idx_q == IDX_W'(i)) pix_data = frame_q[i*DATA_W +: DATA_W];
    end
  end

  assign OUT_Pix_data     = pix_data;
  assign OUT_Pix_valid    = valid_q;
  assign OUT_Pix_index    = idx_q;
  assign OUT_Frame_last   = valid_q & (idx_q == IDX_W'(LAST_IDX));
  assign OUT_Frame_count  = fcnt_q;
  assign OUT_Err_protocol = err_p_q;
  assign OUT_Err_overrun  = err_o_q;
  assign OUT_Cap_FSM      = state_q;

endmodule

// File: tb/tb_re_readout_capture.sv
// tb/tb_re_readout_capture.sv - directed self-checking bench for re_readout_capture
module tb_re_readout_capture;
  import re_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  re_readout_capture_if #(.DATA_W(8), .NCOL(2), .FCNT_W(8)) rif ();

  re_readout_capture #(.DATA_W(8), .NCOL(2), .FCNT_W(8)) dut (
    .IN_Clock         (clk),
    .IN_Reset         (rst_n),
    .IN_Erase         (rif.erase),
    .IN_Expose        (rif.expose),
    .IN_NRE_1         (rif.nre_1),
    .IN_NRE_2         (rif.nre_2),
    .IN_ADC           (rif.adc),
    .IN_Col_data      (rif.col_data),
    .IN_Pix_ready     (rif.pix_ready),
    .IN_Err_clear     (rif.err_clear),
    .OUT_Pix_data     (rif.pix_data),
    .OUT_Pix_valid    (rif.pix_valid),
    .OUT_Pix_index    (rif.pix_index),
    .OUT_Frame_last   (rif.frame_last),
    .OUT_Frame_count  (rif.frame_count),
    .OUT_Err_protocol (rif.err_protocol),
    .OUT_Err_overrun  (rif.err_overrun),
    .OUT_Cap_FSM      (rif.cap_fsm)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_erase();
    rif.erase = 1'b1;
    tick();
    rif.erase = 1'b0;
    tick();
  endtask

  task automatic expose_window(input int n);
    rif.expose = 1'b1;
    repeat (n) tick();
    rif.expose = 1'b0;
    tick();
  endtask

  task automatic adc_row(input int row, input logic [15:0] data);
    rif.adc = 1'b0;
    tick();
    rif.nre_1    = (row == 1);
    rif.nre_2    = (row == 2);
    rif.col_data = data;
    rif.adc      = 1'b1;
    tick();
    rif.adc   = 1'b0;
    rif.nre_1 = 1'b0;
    rif.nre_2 = 1'b0;
  endtask

  task automatic err_clear_pulse();
    rif.err_clear = 1'b1;
    tick();
    rif.err_clear = 1'b0;
  endtask

  // words: word k at bits [k*8 +: 8]; pat: ready level for cycle c is pat[c%4]
  task automatic stream_frame(input logic [31:0] words, input logic [3:0] pat, input int exp_cyc);
    int k;
    int cyc;
    k   = 0;
    cyc = 0;
    while (k < 4 && cyc < 40) begin
      rif.pix_ready = pat[cyc % 4];
      check("stream_valid", rif.pix_valid, 1);
      check("stream_data", rif.pix_data, words[k*8 +: 8]);
      check("stream_index", rif.pix_index, k);
      check("stream_last", rif.frame_last, (k == 3));
      if (pat[cyc % 4]) k++;
      cyc++;
      tick();
    end
    rif.pix_ready = 1'b0;
    check("stream_xfers", k, 4);
    check("stream_cycles", cyc, exp_cyc);
    check("stream_valid_drop", rif.pix_valid, 0);
    check("stream_state_idle", rif.cap_fsm, IDLE);
  endtask

  initial begin
    rif.erase     = 1'b0;
    rif.expose    = 1'b0;
    rif.nre_1     = 1'b0;
    rif.nre_2     = 1'b0;
    rif.adc       = 1'b0;
    rif.col_data  = '0;
    rif.pix_ready = 1'b0;
    rif.err_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_state", rif.cap_fsm, IDLE);
    check("rst_valid", rif.pix_valid, 0);
    check("rst_fcnt", rif.frame_count, 0);
    check("rst_errp", rif.err_protocol, 0);
    check("rst_erro", rif.err_overrun, 0);
    check("rst_index", rif.pix_index, 0);
    check("rst_data", rif.pix_data, 0);
    check("rst_last", rif.frame_last, 0);
    rst_n = 1'b1;
    tick();

    // Nominal frame
    pulse_erase();
    check("t1_armed", rif.cap_fsm, ARMED);
    expose_window(5);
    check("t1_wait_r1", rif.cap_fsm, WAIT_R1);
    adc_row(1, 16'hB2A1);
    check("t1_wait_r2", rif.cap_fsm, WAIT_R2);
    adc_row(2, 16'hD4C3);
    check("t1_send", rif.cap_fsm, SEND);
    stream_frame(32'hD4C3B2A1, 4'b1111, 4);
    check("t1_fcnt", rif.frame_count, 1);
    check("t1_errp", rif.err_protocol, 0);
    check("t1_erro", rif.err_overrun, 0);

    // Backpressure: ready 1,0,0,1 repeating
    pulse_erase();
    expose_window(5);
    adc_row(1, 16'hB2A1);
    adc_row(2, 16'hD4C3);
    stream_frame(32'hD4C3B2A1, 4'b1001, 8);
    check("t2_fcnt", rif.frame_count, 2);

    // Protocol violations
    rif.nre_1 = 1'b1;
    rif.adc   = 1'b1;
    tick();
    check("t3_idle_adc_err", rif.err_protocol, 1);
    check("t3_idle_adc_state", rif.cap_fsm, IDLE);
    rif.adc   = 1'b0;
    rif.nre_1 = 1'b0;
    tick();
    err_clear_pulse();
    check("t3_clear1", rif.err_protocol, 0);
    rif.expose = 1'b1;
    rif.erase  = 1'b1;
    tick();
    check("t3_conflict_err", rif.err_protocol, 1);
    check("t3_conflict_state", rif.cap_fsm, IDLE);
    rif.expose = 1'b0;
    rif.erase  = 1'b0;
    tick();
    err_clear_pulse();
    check("t3_clear2", rif.err_protocol, 0);
    pulse_erase();
    expose_window(2);
    check("t3_wait_r1", rif.cap_fsm, WAIT_R1);
    rif.nre_1 = 1'b1;
    rif.nre_2 = 1'b1;
    rif.adc   = 1'b1;
    tick();
    check("t3_both_nre_err", rif.err_protocol, 1);
    check("t3_both_nre_state", rif.cap_fsm, WAIT_R1);
    rif.adc   = 1'b0;
    rif.nre_1 = 1'b0;
    rif.nre_2 = 1'b0;
    tick();
    err_clear_pulse();
    check("t3_clear3", rif.err_protocol, 0);

    // Abort from WAIT_R2
    adc_row(1, 16'h1111);
    check("t4_wait_r2", rif.cap_fsm, WAIT_R2);
    rif.erase = 1'b1;
    tick();
    check("t4_abort_state", rif.cap_fsm, ARMED);
    check("t4_abort_noerr", rif.err_protocol, 0);
    rif.erase = 1'b0;
    tick();
    expose_window(3);
    check("t4_wait_r1", rif.cap_fsm, WAIT_R1);
    adc_row(1, 16'h6655);
    adc_row(2, 16'h8877);
    check("t4_send", rif.cap_fsm, SEND);
    stream_frame(32'h88776655, 4'b1111, 4);
    check("t4_fcnt", rif.frame_count, 3);

    // Overrun during SEND with ready low
    pulse_erase();
    expose_window(2);
    adc_row(1, 16'h2211);
    adc_row(2, 16'h4433);
    rif.pix_ready = 1'b0;
    tick();
    rif.nre_1 = 1'b1;
    rif.adc   = 1'b1;
    tick();
    check("t5_adc_ovr", rif.err_overrun, 1);
    check("t5_adc_noperr", rif.err_protocol, 0);
    check("t5_adc_state", rif.cap_fsm, SEND);
    check("t5_adc_index", rif.pix_index, 0);
    check("t5_adc_data", rif.pix_data, 8'h11);
    rif.adc       = 1'b0;
    rif.nre_1     = 1'b0;
    rif.err_clear = 1'b1;
    rif.erase     = 1'b1;
    tick();
    check("t5_set_wins", rif.err_overrun, 1);
    rif.erase = 1'b0;
    tick();
    check("t5_cleared", rif.err_overrun, 0);
    rif.err_clear = 1'b0;
    rif.erase     = 1'b1;
    tick();
    check("t5_erase_ovr", rif.err_overrun, 1);
    rif.erase = 1'b0;
    check("t5_state_held", rif.cap_fsm, SEND);
    check("t5_data_held", rif.pix_data, 8'h11);
    stream_frame(32'h44332211, 4'b1111, 4);
    check("t5_fcnt", rif.frame_count, 4);
    check("t5_ovr_sticky", rif.err_overrun, 1);

    // Asynchronous reset mid-SEND
    err_clear_pulse();
    pulse_erase();
    expose_window(2);
    adc_row(1, 16'hBBAA);
    adc_row(2, 16'hDDCC);
    rif.pix_ready = 1'b1;
    tick();
    rif.pix_ready = 1'b0;
    check("t6_index1", rif.pix_index, 1);
    check("t6_data1", rif.pix_data, 8'hBB);
    check("t6_fcnt_pre", rif.frame_count, 4);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", rif.pix_valid, 0);
    check("t6_rst_state", rif.cap_fsm, IDLE);
    check("t6_rst_fcnt", rif.frame_count, 0);
    check("t6_rst_index", rif.pix_index, 0);
    check("t6_rst_data", rif.pix_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
